// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared FSM state type, blink-count width and helpers for the pulse flasher
package flash_pkg;

  localparam int BLINK_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ON,
    S_OFF,
    S_GAP
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/flash_fifo.sv
// rtl/flash_fifo.sv - event queue; a full FIFO still accepts a push when a pop happens in the same cycle
module flash_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pulse_flasher.sv
// rtl/pulse_flasher.sv - queued blink-count LED flasher; ovf port exists only with PULSE_FLASHER_OVF_EN
module pulse_flasher
  import flash_pkg::*;
#(
  parameter int ON_CYCLES  = 12500000,
  parameter int OFF_CYCLES = 12500000,
  parameter int GAP_CYCLES = 50000000,
  parameter int DEPTH      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trig,
  input  logic [BLINK_W-1:0] n_blinks,
  output logic               led,
  output logic               busy
`ifdef PULSE_FLASHER_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int MAX_CYCLES = max3(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  // Counters load N-1 on state entry and leave the state when they reach zero.
  localparam logic [CNT_W-1:0]   ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]   OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [BLINK_W-1:0] REM_ONE  = BLINK_W'(1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BLINK_W-1:0] remaining_q;
  logic               led_q;

  logic [BLINK_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push_ok;

  assign pop     = (state_q == S_IDLE) && !fifo_empty;
  assign push_ok = trig && (!fifo_full || pop);

  flash_fifo #(
    .WIDTH (BLINK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (n_blinks),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      remaining_q <= '0;
      led_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            remaining_q <= fifo_dout;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (remaining_q != '0) begin
            state_q <= S_ON;
            cnt_q   <= ON_LOAD;
            led_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ON: begin
          if (cnt_q == '0) begin
            led_q       <= 1'b0;
            remaining_q <= remaining_q - REM_ONE;
            if (remaining_q != REM_ONE) begin
              state_q <= S_OFF;
              cnt_q   <= OFF_LOAD;
            end else begin
              state_q <= S_GAP;
              cnt_q   <= GAP_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_OFF: begin
          if (cnt_q == '0) begin
            state_q <= S_ON;
            cnt_q   <= ON_LOAD;
            led_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign led  = led_q;
  assign busy = (state_q != S_IDLE) || !fifo_empty;

`ifdef PULSE_FLASHER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= trig && !push_ok;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pulse_flasher.sv
// tb/tb_pulse_flasher.sv - scoreboard bench for pulse_flasher (ON=3, OFF=2, GAP=4, DEPTH=4)
module tb_pulse_flasher;

  typedef struct packed {
    logic       trig;
    logic [3:0] n;
    logic       rst;
  } stim_t;

  typedef struct packed {
    logic led;
    logic busy;
    logic ovf;
  } obs_t;

`ifdef PULSE_FLASHER_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [3:0] n_blinks = 4'd0;
  logic       led;
  logic       busy;
`ifdef PULSE_FLASHER_OVF_EN
  logic       ovf;
`endif

  stim_t stim_q[$];
  obs_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  pulse_flasher #(
    .ON_CYCLES  (3),
    .OFF_CYCLES (2),
    .GAP_CYCLES (4),
    .DEPTH      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .trig     (trig),
    .n_blinks (n_blinks),
    .led      (led),
    .busy     (busy)
`ifdef PULSE_FLASHER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic add_stim(input logic t, input logic [3:0] n, input logic r, input int count);
    for (int i = 0; i < count; i++) stim_q.push_back('{trig: t, n: n, rst: r});
  endtask

  task automatic add_exp(input logic l, input logic b, input logic o, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back('{led: l, busy: b, ovf: o});
  endtask

  // Applies the next queued stimulus (idle when none) across one rising edge and samples just after it.
  task automatic step(output obs_t o);
    stim_t s;
    s = '{trig: 1'b0, n: 4'd0, rst: 1'b0};
    if (stim_q.size() != 0) s = stim_q.pop_front();
    trig     = s.trig;
    n_blinks = s.n;
    rst      = s.rst;
    @(posedge clk);
    #1;
    o.led  = led;
    o.busy = busy;
`ifdef PULSE_FLASHER_OVF_EN
    o.ovf  = ovf;
`else
    o.ovf  = 1'b0;
`endif
  endtask

  task automatic test_reset();
    obs_t o, e;
    int cyc = 0;
    add_stim(1'b1, 4'd5, 1'b1, 2);
    add_stim(1'b0, 4'd0, 1'b0, 1);
    add_exp(1'b0, 1'b0, 1'b0, 3);
    while (exp_q.size() != 0) begin
      step(o);
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset cycle %0d {led,busy,ovf} got %b expected %b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_two_blinks();
    obs_t o, e;
    int cyc = 0;
    add_stim(1'b1, 4'd2, 1'b0, 1);
    add_exp(1'b0, 1'b1, 1'b0, 2);
    add_exp(1'b1, 1'b1, 1'b0, 3);
    add_exp(1'b0, 1'b1, 1'b0, 2);
    add_exp(1'b1, 1'b1, 1'b0, 3);
    add_exp(1'b0, 1'b1, 1'b0, 4);
    add_exp(1'b0, 1'b0, 1'b0, 2);
    while (exp_q.size() != 0) begin
      step(o);
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL two_blinks cycle %0d {led,busy,ovf} got %b expected %b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_zero_blinks();
    obs_t o, e;
    int cyc = 0;
    add_stim(1'b1, 4'd0, 1'b0, 1);
    add_exp(1'b0, 1'b1, 1'b0, 2);
    add_exp(1'b0, 1'b0, 1'b0, 3);
    while (exp_q.size() != 0) begin
      step(o);
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL zero_blinks cycle %0d {led,busy,ovf} got %b expected %b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  // Six single-blink triggers: the first is popped straight away, four fill the queue, the sixth is dropped.
  task automatic test_back_to_back();
    obs_t o, e;
    int cyc = 0;
    add_stim(1'b1, 4'd1, 1'b0, 6);
    add_exp(1'b0, 1'b1, 1'b0, 2);
    add_exp(1'b1, 1'b1, 1'b0, 3);
    add_exp(1'b0, 1'b1, OVF_EN, 1);
    add_exp(1'b0, 1'b1, 1'b0, 3);
    for (int k = 1; k < 5; k++) begin
      add_exp(1'b0, 1'b1, 1'b0, 2);
      add_exp(1'b1, 1'b1, 1'b0, 3);
      add_exp(1'b0, 1'b1, 1'b0, 4);
    end
    add_exp(1'b0, 1'b0, 1'b0, 2);
    while (exp_q.size() != 0) begin
      step(o);
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d {led,busy,ovf} got %b expected %b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  // Queue is full when the FSM pops at edge 10; the trig on that edge must be kept and serviced last.
  task automatic test_full_pop();
    obs_t o, e;
    int cyc = 0;
    add_stim(1'b1, 4'd1, 1'b0, 5);
    add_stim(1'b0, 4'd0, 1'b0, 5);
    add_stim(1'b1, 4'd2, 1'b0, 1);
    for (int k = 0; k < 5; k++) begin
      add_exp(1'b0, 1'b1, 1'b0, 2);
      add_exp(1'b1, 1'b1, 1'b0, 3);
      add_exp(1'b0, 1'b1, 1'b0, 4);
    end
    add_exp(1'b0, 1'b1, 1'b0, 2);
    add_exp(1'b1, 1'b1, 1'b0, 3);
    add_exp(1'b0, 1'b1, 1'b0, 2);
    add_exp(1'b1, 1'b1, 1'b0, 3);
    add_exp(1'b0, 1'b1, 1'b0, 4);
    add_exp(1'b0, 1'b0, 1'b0, 2);
    while (exp_q.size() != 0) begin
      step(o);
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL full_pop cycle %0d {led,busy,ovf} got %b expected %b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid_blink();
    obs_t o, e;
    int cyc = 0;
    add_stim(1'b1, 4'd3, 1'b0, 1);
    add_stim(1'b1, 4'd1, 1'b0, 2);
    add_stim(1'b0, 4'd0, 1'b0, 1);
    add_stim(1'b0, 4'd0, 1'b1, 1);
    add_exp(1'b0, 1'b1, 1'b0, 2);
    add_exp(1'b1, 1'b1, 1'b0, 2);
    add_exp(1'b0, 1'b0, 1'b0, 11);
    while (exp_q.size() != 0) begin
      step(o);
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_mid_blink cycle %0d {led,busy,ovf} got %b expected %b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_two_blinks();
    test_zero_blinks();
    test_back_to_back();
    test_full_pop();
    test_reset_mid_blink();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_flasher.md
PULSE_FLASHER -- requirements
Module: pulse_flasher

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 12500000, LED-high time per blink in clk cycles (min 1).
REQ-002 SHALL have parameter OFF_CYCLES, default 12500000, LED-low time between blinks of one event (min 1).
REQ-003 SHALL have parameter GAP_CYCLES, default 50000000, LED-low time after the last blink of an event (min 1).
REQ-004 SHALL have parameter DEPTH, default 4, event queue depth (power of two, 2..16).
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port trig  input  1  single-cycle event pulse, e.g. from Button.
REQ-008 SHALL have port n_blinks  input  4  blink count for the event, sampled with trig.
REQ-009 SHALL have port led  output  1  registered LED drive, active high.
REQ-010 SHALL have port busy  output  1  high while the FSM is not IDLE or the queue is non-empty.
REQ-011 SHALL have port ovf  output  1  one-cycle pulse on a dropped trig (only with PULSE_FLASHER_OVF_EN).

Function
REQ-012 SHALL push n_blinks into a FIFO on every clk edge where trig=1; trig held high N cycles SHALL push N entries.
REQ-013 SHALL drop the push when the FIFO is full, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-014 SHALL run FSM states IDLE, LOAD, ON, OFF, GAP.
REQ-015 IDLE->LOAD when FIFO non-empty: pop the head into a 4-bit remaining counter.
REQ-016 LOAD->ON if remaining!=0 (led=1 from the next edge), else LOAD->IDLE with no LED activity and no gap.
REQ-017 ON lasts exactly ON_CYCLES cycles, then decrements remaining; ->OFF if remaining>0, else ->GAP.
REQ-018 OFF lasts exactly OFF_CYCLES cycles, then ->ON; GAP lasts exactly GAP_CYCLES cycles, then ->IDLE.
REQ-019 led SHALL be 1 only in ON; led is a flop, with no combinational path from trig.
REQ-020 Latency: trig at edge t into an empty FIFO in IDLE -> led=1 sampled after edge t+2.
REQ-021 The cycle counter width SHALL be $clog2(max(ON,OFF,GAP)); the counter SHALL reload at each state entry and SHALL never wrap.
REQ-022 Events SHALL be serviced strictly in FIFO order; a trig during ON/OFF/GAP SHALL never alter the current event.

Reset
REQ-023 rst SHALL clear the FIFO (empty), FSM=IDLE, counters=0, led=0, busy=0, ovf=0 on the next edge, including mid-blink.
REQ-024 A trig in the same cycle as rst SHALL be discarded.

Configuration
REQ-025 With `PULSE_FLASHER_OVF_EN` defined: ovf port present; ovf=1 for exactly the cycle after each dropped push (REQ-013).
REQ-026 Without it: no ovf port; drops are silent; all other behaviour is identical.

Structure
REQ-027 Shared package flash_pkg SHALL hold the FSM state enum and BLINK_W=4.
REQ-028 The FIFO SHALL be sub-module flash_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty).

Verification (ON=3, OFF=2, GAP=4, DEPTH=4)
REQ-029 trig with n_blinks=2 -> led 0,0 then 1x3, 0x2, 1x3, 0x4; busy drops after the GAP.
REQ-030 trig with n_blinks=0 -> led stays 0; busy high for exactly 2 cycles.
REQ-031 5 triggers back-to-back while IDLE with n=1 -> the first is popped at LOAD, so all 5 are accepted and 5 blinks result; 6 triggers -> 6th dropped, ovf pulse (with macro).
REQ-032 rst asserted in the 2nd ON cycle of a 3-blink event with 2 queued -> led=0 next cycle, busy=0, no further blinks.
REQ-033 FIFO full while the FSM pops in the same cycle as trig -> push accepted, no ovf.
REQ-034 Build without PULSE_FLASHER_OVF_EN -> repeat of REQ-031 shows identical led trace and no ovf port.
